// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and defaults for the datapath register bank.
// Holds the clear-sweep state encoding and default geometry.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;

endpackage

// File: rtl/reg_file_clear_seq.sv
// reg_file_clear_seq: sweeps the bank to zero one register per cycle.
// Drives sweepEn/sweepAddr and the busy/done/dropped status pulses.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clearReq,
  input  logic              regWrite,
  output logic              sweepEn,
  output logic [ADDR_W-1:0] sweepAddr,
  output logic              clearBusy,
  output logic              clearDone,
  output logic              writeDropped
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  sweep_state_t      state;
  logic [ADDR_W-1:0] ptr;

  // Sweep FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      clearBusy    <= 1'b0;
      clearDone    <= 1'b0;
      writeDropped <= 1'b0;
    end else begin
      clearDone    <= 1'b0;
      writeDropped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clearReq) begin
            state     <= SWEEP;
            ptr       <= '0;
            clearBusy <= 1'b1;
          end
        end
        SWEEP: begin
          writeDropped <= regWrite;
          if (ptr == LAST) begin
            state     <= IDLE;
            ptr       <= '0;
            clearBusy <= 1'b0;
            clearDone <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign sweepEn   = (state == SWEEP);
  assign sweepAddr = ptr;

endmodule

// File: rtl/reg_file_bank.sv
// reg_file_bank: 2-read/1-write register file with pending scoreboard,
// optional write bypass, optional zero register and a clear sweep.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  output logic [DATA_W-1:0] reg1Data,
  output logic [DATA_W-1:0] reg2Data,
  output logic              reg1Pending,
  output logic              reg2Pending,
  input  logic              markPending,
  input  logic [ADDR_W-1:0] pendReg,
  input  logic              clearReq,
  output logic              clearBusy,
  output logic              clearDone,
  output logic              writeDropped
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                sweepEn;
  logic [ADDR_W-1:0]   sweepAddr;
  logic                wrEn;

  reg_file_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear (
    .clk          (clk),
    .rst_n        (rst_n),
    .clearReq     (clearReq),
    .regWrite     (regWrite),
    .sweepEn      (sweepEn),
    .sweepAddr    (sweepAddr),
    .clearBusy    (clearBusy),
    .clearDone    (clearDone),
    .writeDropped (writeDropped)
  );

  // Writes are only accepted while no sweep is running.
  assign wrEn = regWrite & ~sweepEn;

  // Storage: sweep clear beats writeback; register 0 may be hard zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sweepEn && sweepAddr == ADDR_W'(i)) begin
          regs[i] <= '0;
        end else if (wrEn && writeReg == ADDR_W'(i) &&
                     !(ZERO_REG != 0 && i == 0)) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  // Pending bits: sweep clears, then a mark wins over a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sweepEn && sweepAddr == ADDR_W'(i)) begin
          pending[i] <= 1'b0;
        end else if (markPending && pendReg == ADDR_W'(i) &&
                     !(ZERO_REG != 0 && i == 0)) begin
          pending[i] <= 1'b1;
        end else if (wrEn && writeReg == ADDR_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports: stored value, optional bypass, zero register last.
  always_comb begin
    reg1Data = regs[reg1];
    reg2Data = regs[reg2];
    if (BYPASS != 0 && wrEn && writeReg == reg1) reg1Data = writeData;
    if (BYPASS != 0 && wrEn && writeReg == reg2) reg2Data = writeData;
    if (ZERO_REG != 0 && reg1 == '0) reg1Data = '0;
    if (ZERO_REG != 0 && reg2 == '0) reg2Data = '0;
  end

  assign reg1Pending = pending[reg1];
  assign reg2Pending = pending[reg2];

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed scoreboard bench for reg_file_bank.
// Three instances share stimulus: default, no-bypass, zero-register.
module tb_reg_file_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       regWrite;
  logic [2:0] writeReg;
  logic [7:0] writeData;
  logic [2:0] reg1, reg2;
  logic       markPending;
  logic [2:0] pendReg;
  logic       clearReq;

  logic [7:0] d1, d2, n1, n2, z1, z2;
  logic       p1, p2, np1, np2, zp1, zp2;
  logic       busy, done, drop;
  logic       nbusy, ndone, ndrop, zbusy, zdone, zdrop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  reg_file_bank dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData),
    .reg1(reg1), .reg2(reg2), .reg1Data(d1), .reg2Data(d2),
    .reg1Pending(p1), .reg2Pending(p2),
    .markPending(markPending), .pendReg(pendReg),
    .clearReq(clearReq), .clearBusy(busy), .clearDone(done),
    .writeDropped(drop)
  );

  reg_file_bank #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData),
    .reg1(reg1), .reg2(reg2), .reg1Data(n1), .reg2Data(n2),
    .reg1Pending(np1), .reg2Pending(np2),
    .markPending(markPending), .pendReg(pendReg),
    .clearReq(clearReq), .clearBusy(nbusy), .clearDone(ndone),
    .writeDropped(ndrop)
  );

  reg_file_bank #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData),
    .reg1(reg1), .reg2(reg2), .reg1Data(z1), .reg2Data(z2),
    .reg1Pending(zp1), .reg2Pending(zp2),
    .markPending(markPending), .pendReg(pendReg),
    .clearReq(clearReq), .clearBusy(zbusy), .clearDone(zdone),
    .writeDropped(zdrop)
  );

  task automatic push(input string tag, input logic [7:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads every register of the default instance, two per ns.
  task automatic rdall(input string tag, input logic [7:0] v);
    for (int j = 0; j < 4; j++) begin
      reg1 = 3'(2 * j);
      reg2 = 3'(2 * j + 1);
      push(tag, v);
      push(tag, v);
      #1;
      check(d1);
      check(d2);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      regWrite  = 1'b1;
      writeReg  = 3'(i);
      writeData = 8'(17 * (i + 1));
      tick();
    end
    regWrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    reg1 = '0; reg2 = '0; markPending = 1'b0; pendReg = '0;
    clearReq = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state
    rdall("rst_data", 8'h00);
    for (int i = 0; i < 8; i++) begin
      reg1 = 3'(i);
      push("rst_pend", 8'h0);
      #0.1;
      check(8'(p1));
    end
    push("rst_busy", 8'h0); check(8'(busy));
    push("rst_done", 8'h0); check(8'(done));
    push("rst_drop", 8'h0); check(8'(drop));

    // basic write then read
    regWrite = 1'b1; writeReg = 3'd3; writeData = 8'hA5;
    tick();
    regWrite = 1'b0; reg1 = 3'd3;
    push("wr_rd3", 8'hA5);
    #1; check(d1);

    // bypass vs no bypass
    tick();
    regWrite = 1'b1; writeReg = 3'd5; writeData = 8'h3C; reg2 = 3'd5;
    push("byp_on", 8'h3C);
    push("byp_off_old", 8'h00);
    #1; check(d2); check(n2);
    tick();
    regWrite = 1'b0;
    push("byp_off_new", 8'h3C);
    #1; check(n2);

    // zero register
    regWrite = 1'b1; writeReg = 3'd0; writeData = 8'hFF;
    markPending = 1'b1; pendReg = 3'd0; reg1 = 3'd0;
    push("zr_byp_data", 8'h00);
    push("nz_byp_data", 8'hFF);
    #1; check(z1); check(d1);
    tick();
    regWrite = 1'b0; markPending = 1'b0;
    push("zr_data", 8'h00);
    push("zr_pend", 8'h0);
    push("nz_data", 8'hFF);
    push("nz_pend_markwins", 8'h1);
    #1; check(z1); check(8'(zp1)); check(d1); check(8'(p1));

    // pending scoreboard
    markPending = 1'b1; pendReg = 3'd2;
    tick();
    markPending = 1'b0; reg1 = 3'd2;
    push("pend_mark2", 8'h1);
    #1; check(8'(p1));
    regWrite = 1'b1; writeReg = 3'd2; writeData = 8'h22;
    tick();
    regWrite = 1'b0;
    push("pend_wr2", 8'h0);
    #1; check(8'(p1));
    regWrite = 1'b1; writeReg = 3'd4; writeData = 8'h44;
    markPending = 1'b1; pendReg = 3'd4;
    tick();
    regWrite = 1'b0; markPending = 1'b0; reg1 = 3'd4;
    push("pend_markwr4", 8'h1);
    push("data_markwr4", 8'h44);
    #1; check(8'(p1)); check(d1);

    // full clear sweep
    fill();
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push("sweep_busy", 8'h1);
      check(8'(busy));
      if (k == 1) begin
        reg1 = 3'd0; reg2 = 3'd7;
        push("sweep_r0", 8'h00);
        push("sweep_r7", 8'h88);
        #1; check(d1); check(d2);
        regWrite = 1'b1; writeReg = 3'd7; writeData = 8'h5A;
        push("sweep_nobyp", 8'h88);
        #1; check(d2);
      end
      if (k == 2) begin
        regWrite = 1'b0;
        push("sweep_drop", 8'h1);
        check(8'(drop));
      end
      if (k == 3) begin
        push("sweep_drop_end", 8'h0);
        check(8'(drop));
      end
      tick();
    end
    push("sweep_busy_end", 8'h0); check(8'(busy));
    push("sweep_done", 8'h1); check(8'(done));
    rdall("sweep_zero", 8'h00);
    tick();
    push("sweep_done_end", 8'h0); check(8'(done));

    // reset in the middle of a sweep
    fill();
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    tick(); tick(); tick();
    reg1 = 3'd3; reg2 = 3'd2;
    push("part_r3", 8'h44);
    push("part_r2", 8'h00);
    #1; check(d1); check(d2);
    rst_n = 1'b0;
    #0.5;
    push("midrst_busy", 8'h0); check(8'(busy));
    rdall("midrst_zero", 8'h00);
    rst_n = 1'b1;
    tick();
    push("postrst_busy", 8'h0); check(8'(busy));
    regWrite = 1'b1; writeReg = 3'd6; writeData = 8'h66;
    tick();
    regWrite = 1'b0; reg1 = 3'd6;
    push("postrst_wr6", 8'h66);
    #1; check(d1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

- Parametrised, reset-able register file for the datapath: configurable width and depth, two combinational read ports, one write port.
- Optional write-to-read bypass and an optional hard-wired zero register.
- Per-register pending scoreboard for hazard detection.
- Clear sequencer that zeroes the whole bank one register per cycle on request.
- Sits between decode (read addresses, pending marks) and writeback (write port).

## Interface
Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register address width (derived, do not override)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and pending marks to it are ignored

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- regWrite  in  1  write enable
- writeReg  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- reg1, reg2  in  ADDR_W  read addresses
- reg1Data, reg2Data  out  DATA_W  read data (combinational)
- reg1Pending, reg2Pending  out  1  pending bit of reg1/reg2 (combinational)
- markPending  in  1  set pending bit of pendReg
- pendReg  in  ADDR_W  register to mark pending
- clearReq  in  1  start clear sweep (sampled in IDLE only)
- clearBusy  out  1  sweep in progress (registered)
- clearDone  out  1  one-cycle pulse after sweep ends (registered)
- writeDropped  out  1  one-cycle pulse: a regWrite was discarded during the sweep (registered)

## Operation
- Reset (rst_n low, any time):
  - All registers 0 and all pending bits 0.
  - FSM goes to IDLE and the sweep pointer goes to 0.
  - clearBusy, clearDone and writeDropped go to 0.
  - A sweep in progress is abandoned.
- Write: in IDLE with regWrite=1, registers[writeReg] ← writeData at the edge and pending[writeReg] is cleared.
- Read:
  - regXData = registers[regX].
  - If BYPASS=1, regWrite=1, state is IDLE and writeReg==regX, regXData = writeData.
  - ZERO_REG=1 and regX==0 gives 0 regardless of the above.
- Pending:
  - markPending sets pending[pendReg].
  - Mark and write to the same register in the same cycle: the mark wins and the bit ends set.
  - regXPending is not bypassed; it shows the registered bit.
- FSM states:
  - IDLE: clearReq=1 → SWEEP with ptr=0 and clearBusy←1.
  - SWEEP: each edge, registers[ptr]←0, pending[ptr]←0 and ptr++.
  - When ptr==NUM_REGS-1 the FSM returns to IDLE with clearBusy←0 and clearDone←1 for one cycle.
- During SWEEP:
  - regWrite is discarded and writeDropped pulses at the following edge.
  - markPending is still honoured except on the register being swept that cycle; there the sweep wins.
  - Reads return current stored contents, so the bank can be partially cleared.
  - clearReq is ignored.
- Widths: data is stored exactly DATA_W bits with no extension. Addresses are ADDR_W bits, so all addresses are in range.

## Timing
- Read and pending outputs are combinational, with zero-cycle latency from the address inputs.
- A write is visible on read ports the cycle after the edge, or in the same cycle via bypass.
- A clearReq sampled at edge E0 gives:
  - clearBusy high from E0 to E0+NUM_REGS.
  - Register i cleared at edge E0+1+i.
  - clearDone high for exactly one cycle after E0+NUM_REGS.
- clearReq held high through clearDone starts a new sweep at the edge where clearDone is high, because state is IDLE then.
- Reset asserted mid-sweep gives outputs of 0 immediately, since reset is asynchronous. After deassertion the block is in IDLE.

## Structure
- Shared package reg_file_pkg holds:
  - The sweep state enum typedef (IDLE, SWEEP).
  - Default DATA_W/NUM_REGS constants.
- One sub-module: reg_file_clear_seq, containing the FSM, sweep pointer, clearBusy/clearDone and writeDropped generation. It outputs sweepEn and sweepAddr to the storage array.
- Storage array, bypass muxes and pending bits live in reg_file_bank.

## Test plan
- Reset with defaults: all reads 0 and all pending 0. Write 8'hA5 to reg 3, then read reg1=3 next cycle → 8'hA5.
- BYPASS=1: regWrite with writeReg=5, writeData=8'h3C, reg2=5 in the same cycle → reg2Data=8'h3C. With BYPASS=0 it shows the old value 0 that cycle and 8'h3C next cycle.
- ZERO_REG=1: write 8'hFF to reg 0 and markPending reg 0 → reg1Data=0 and reg1Pending=0 for reg1=0.
- Pending:
  - markPending reg 2 → reg1Pending=1.
  - Write reg 2 → pending 0 next cycle.
  - Same-cycle mark and write on reg 4 → pending 1.
- Fill all 8 regs with 8'h11..8'h88, then pulse clearReq:
  - clearBusy high for 8 cycles.
  - Reg 0 reads 0 after the first sweep edge while reg 7 still reads 8'h88.
  - A regWrite during the sweep → writeDropped pulse and no write.
  - clearDone pulses once and all regs read 0.
- Assert rst_n low mid-sweep (after 3 registers cleared) → clearBusy 0 immediately and all regs 0. After release a write to reg 6 succeeds normally.
